// File: rtl/sha256_processor_dvirdc.sv
// Single-block SHA-256 compression engine behind an 8-bit GPIO host interface.
// Optional SHA256_MULTIBLOCK_EN: start with cont=1 chains from the previous digest.
module sha256_processor_dvirdc (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  output logic [7:0] uo_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FINAL = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  wptr_q, wptr_d;
  logic [4:0]  rptr_q, rptr_d;
  logic [5:0]  t_q, t_d;
  logic [31:0] w_q    [16];
  logic [31:0] w_d    [16];
  logic [31:0] wk_q   [8];
  logic [31:0] wk_d   [8];
  logic [31:0] base_q [8];
  logic [31:0] base_d [8];
  logic [31:0] dig_q  [8];
  logic [31:0] dig_d  [8];

  logic wr, start, rd_next, use_h, busy, done;
  logic unused_ok;

  assign wr      = uio_in[0];
  assign start   = uio_in[1];
  assign rd_next = uio_in[2];

`ifdef SHA256_MULTIBLOCK_EN
  assign use_h     = uio_in[3];
  assign unused_ok = ^{ena, uio_in[7:4]};
`else
  assign use_h     = 1'b0;
  assign unused_ok = ^{ena, uio_in[7:3]};
`endif

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_s0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_s1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] iv_word(input logic [2:0] i);
    case (i)
      3'd0:    return 32'h6a09e667;
      3'd1:    return 32'hbb67ae85;
      3'd2:    return 32'h3c6ef372;
      3'd3:    return 32'ha54ff53a;
      3'd4:    return 32'h510e527f;
      3'd5:    return 32'h9b05688c;
      3'd6:    return 32'h1f83d9ab;
      default: return 32'h5be0cd19;
    endcase
  endfunction

  function automatic logic [31:0] k_word(input logic [5:0] t);
    case (t)
      6'd0:  return 32'h428a2f98; 6'd1:  return 32'h71374491;
      6'd2:  return 32'hb5c0fbcf; 6'd3:  return 32'he9b5dba5;
      6'd4:  return 32'h3956c25b; 6'd5:  return 32'h59f111f1;
      6'd6:  return 32'h923f82a4; 6'd7:  return 32'hab1c5ed5;
      6'd8:  return 32'hd807aa98; 6'd9:  return 32'h12835b01;
      6'd10: return 32'h243185be; 6'd11: return 32'h550c7dc3;
      6'd12: return 32'h72be5d74; 6'd13: return 32'h80deb1fe;
      6'd14: return 32'h9bdc06a7; 6'd15: return 32'hc19bf174;
      6'd16: return 32'he49b69c1; 6'd17: return 32'hefbe4786;
      6'd18: return 32'h0fc19dc6; 6'd19: return 32'h240ca1cc;
      6'd20: return 32'h2de92c6f; 6'd21: return 32'h4a7484aa;
      6'd22: return 32'h5cb0a9dc; 6'd23: return 32'h76f988da;
      6'd24: return 32'h983e5152; 6'd25: return 32'ha831c66d;
      6'd26: return 32'hb00327c8; 6'd27: return 32'hbf597fc7;
      6'd28: return 32'hc6e00bf3; 6'd29: return 32'hd5a79147;
      6'd30: return 32'h06ca6351; 6'd31: return 32'h14292967;
      6'd32: return 32'h27b70a85; 6'd33: return 32'h2e1b2138;
      6'd34: return 32'h4d2c6dfc; 6'd35: return 32'h53380d13;
      6'd36: return 32'h650a7354; 6'd37: return 32'h766a0abb;
      6'd38: return 32'h81c2c92e; 6'd39: return 32'h92722c85;
      6'd40: return 32'ha2bfe8a1; 6'd41: return 32'ha81a664b;
      6'd42: return 32'hc24b8b70; 6'd43: return 32'hc76c51a3;
      6'd44: return 32'hd192e819; 6'd45: return 32'hd6990624;
      6'd46: return 32'hf40e3585; 6'd47: return 32'h106aa070;
      6'd48: return 32'h19a4c116; 6'd49: return 32'h1e376c08;
      6'd50: return 32'h2748774c; 6'd51: return 32'h34b0bcb5;
      6'd52: return 32'h391c0cb3; 6'd53: return 32'h4ed8aa4a;
      6'd54: return 32'h5b9cca4f; 6'd55: return 32'h682e6ff3;
      6'd56: return 32'h748f82ee; 6'd57: return 32'h78a5636f;
      6'd58: return 32'h84c87814; 6'd59: return 32'h8cc70208;
      6'd60: return 32'h90befffa; 6'd61: return 32'ha4506ceb;
      6'd62: return 32'hbef9a3f7; default: return 32'hc67178f2;
    endcase
  endfunction

  // The window always holds W_t..W_t+15, so W_t is w_q[0] and the shifted-in
  // word is W_t+16; the same expansion works for every round.
  logic [31:0] t1, t2, w_new;
  always_comb begin
    t1 = wk_q[7] + big_s1(wk_q[4]) + ((wk_q[4] & wk_q[5]) ^ (~wk_q[4] & wk_q[6]))
       + k_word(t_q) + w_q[0];
    t2 = big_s0(wk_q[0]) + ((wk_q[0] & wk_q[1]) ^ (wk_q[0] & wk_q[2]) ^ (wk_q[1] & wk_q[2]));
    w_new = small_s1(w_q[14]) + w_q[9] + small_s0(w_q[1]) + w_q[0];
  end

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    t_d     = t_q;
    for (int i = 0; i < 16; i++) w_d[i] = w_q[i];
    for (int i = 0; i < 8; i++) begin
      wk_d[i]   = wk_q[i];
      base_d[i] = base_q[i];
      dig_d[i]  = dig_q[i];
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (state_q == S_DONE && rd_next) rptr_d = rptr_q + 5'd1;
        if (start) begin
          for (int i = 0; i < 8; i++) begin
            wk_d[i]   = use_h ? dig_q[i] : iv_word(3'(i));
            base_d[i] = use_h ? dig_q[i] : iv_word(3'(i));
          end
          wptr_d  = 6'd0;
          rptr_d  = 5'd0;
          t_d     = 6'd0;
          state_d = S_RUN;
        end else if (wr) begin
          for (int i = 0; i < 16; i++)
            for (int j = 0; j < 4; j++)
              if (wptr_q == 6'(i * 4 + j)) w_d[i][31 - 8 * j -: 8] = ui_in;
          wptr_d = wptr_q + 6'd1;
        end
      end
      S_RUN: begin
        wk_d[0] = t1 + t2;
        wk_d[1] = wk_q[0];
        wk_d[2] = wk_q[1];
        wk_d[3] = wk_q[2];
        wk_d[4] = wk_q[3] + t1;
        wk_d[5] = wk_q[4];
        wk_d[6] = wk_q[5];
        wk_d[7] = wk_q[6];
        for (int i = 0; i < 15; i++) w_d[i] = w_q[i + 1];
        w_d[15] = w_new;
        t_d     = t_q + 6'd1;
        if (t_q == 6'd63) state_d = S_FINAL;
      end
      S_FINAL: begin
        for (int i = 0; i < 8; i++) dig_d[i] = base_q[i] + wk_q[i];
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      wptr_q  <= 6'd0;
      rptr_q  <= 5'd0;
      t_q     <= 6'd0;
      for (int i = 0; i < 16; i++) w_q[i] <= 32'd0;
      for (int i = 0; i < 8; i++) begin
        wk_q[i]   <= 32'd0;
        base_q[i] <= 32'd0;
        dig_q[i]  <= 32'd0;
      end
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      t_q     <= t_d;
      for (int i = 0; i < 16; i++) w_q[i] <= w_d[i];
      for (int i = 0; i < 8; i++) begin
        wk_q[i]   <= wk_d[i];
        base_q[i] <= base_d[i];
        dig_q[i]  <= dig_d[i];
      end
    end
  end

  logic [31:0] sel_word;
  logic [7:0]  sel_byte;
  always_comb begin
    sel_word = dig_q[rptr_q[4:2]];
    case (rptr_q[1:0])
      2'd0:    sel_byte = sel_word[31:24];
      2'd1:    sel_byte = sel_word[23:16];
      2'd2:    sel_byte = sel_word[15:8];
      default: sel_byte = sel_word[7:0];
    endcase
  end

  assign busy    = (state_q == S_RUN) || (state_q == S_FINAL);
  assign done    = (state_q == S_DONE);
  assign uio_out = {1'b0, ~busy, done, busy, 4'b0000};
  assign uio_oe  = 8'hF0;
  assign uo_out  = done ? sel_byte : 8'h00;

endmodule

// File: tb/tb_sha256_processor_dvirdc.sv
// Directed bench for sha256_processor_dvirdc: known FIPS digests read back
// through a scoreboard queue, plus timing, interference and reset checks.
module tb_sha256_processor_dvirdc;

  logic       clk, rst, ena;
  logic [7:0] ui_in, uio_in, uio_out, uio_oe, uo_out;

  sha256_processor_dvirdc dut (
    .clk(clk), .rst(rst), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uio_out(uio_out), .uio_oe(uio_oe), .uo_out(uo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int tests_run = 0;
  int fail_cnt  = 0;
  logic [7:0] exp_q[$];
  logic [7:0] msg [64];

  localparam logic [255:0] D_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] D_TWO   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  // Output is valid while done=1; a byte is consumed on a cycle with rd_next=1.
  always @(negedge clk) begin
    if (!rst && uio_out[5] && uio_in[2]) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        fail_cnt++;
        $display("FAIL digest_read: unexpected read, got %h with empty queue", uo_out);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (uo_out !== e) begin
          fail_cnt++;
          $display("FAIL digest_read: got %h expected %h", uo_out, e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic [7:0] d, input logic [3:0] ctl);
    ui_in  = d;
    uio_in = {4'h0, ctl};
    @(posedge clk);
    #1;
    uio_in = 8'h00;
    ui_in  = 8'h00;
  endtask

  task automatic load_msg();
    for (int i = 0; i < 64; i++) cyc(msg[i], 4'b0001);
  endtask

  task automatic set_abc();
    for (int i = 0; i < 64; i++) msg[i] = 8'h00;
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63; msg[3] = 8'h80; msg[63] = 8'h18;
  endtask

  task automatic set_empty();
    for (int i = 0; i < 64; i++) msg[i] = 8'h00;
    msg[0] = 8'h80;
  endtask

  // Waits out busy (bounded), optionally poking wr/start/rd_next/cont meanwhile.
  task automatic wait_done(input bit disturb);
    int n;
    n = 0;
    while (uio_out[4] && n < 200) begin
      uio_in = 8'h00;
      if (disturb) begin
        case (n)
          5:  begin ui_in = 8'haa; uio_in = 8'h01; end
          10: uio_in = 8'h02;
          20: uio_in = 8'h04;
          30: begin ui_in = 8'h55; uio_in = 8'h0f; end
          default: ;
        endcase
      end
      @(posedge clk);
      #1;
      n++;
    end
    uio_in = 8'h00;
    check("busy_cycles", 32'(n), 32'd65);
    check("status_done", 32'(uio_out), 32'h60);
  endtask

  task automatic read_digest(input logic [255:0] d, input int count);
    for (int i = 0; i < count; i++) begin
      exp_q.push_back(d[255 - 8 * (i % 32) -: 8]);
      cyc(8'h00, 4'b0100);
    end
  endtask

  initial begin
    ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00; rst = 1'b1;
    #1;
    check("reset_status", 32'(uio_out), 32'h40);
    check("reset_uo_out", 32'(uo_out), 32'h00);
    check("reset_uio_oe", 32'(uio_oe), 32'hf0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // "abc": full digest and the 31->0 wrap on the 33rd read.
    set_abc();
    load_msg();
    check("idle_uo_out", 32'(uo_out), 32'h00);
    cyc(8'h00, 4'b0010);
    wait_done(1'b0);
    read_digest(D_ABC, 33);

    // Empty message loaded while the previous digest is still in DONE.
    set_empty();
    load_msg();
    cyc(8'h00, 4'b0010);
    check("done_cleared", 32'(uio_out), 32'h10);
    wait_done(1'b0);
    read_digest(D_EMPTY, 32);

    // wr+start together drops the byte; wr/start/rd_next/cont while busy ignored.
    set_abc();
    load_msg();
    cyc(8'hff, 4'b0011);
    wait_done(1'b1);
    read_digest(D_ABC, 32);

`ifdef SHA256_MULTIBLOCK_EN
    for (int i = 0; i < 64; i++) msg[i] = 8'h00;
    for (int g = 0; g < 14; g++)
      for (int j = 0; j < 4; j++) msg[g * 4 + j] = 8'(8'h61 + g + j);
    msg[56] = 8'h80;
    load_msg();
    cyc(8'h00, 4'b0010);
    wait_done(1'b0);
    for (int i = 0; i < 64; i++) msg[i] = 8'h00;
    msg[62] = 8'h01; msg[63] = 8'hc0;
    load_msg();
    cyc(8'h00, 4'b1010);
    wait_done(1'b0);
    read_digest(D_TWO, 32);
`else
    // cont=1 after an "abc" run must still start from the IV.
    set_empty();
    load_msg();
    cyc(8'h00, 4'b1010);
    wait_done(1'b0);
    read_digest(D_EMPTY, 32);
`endif

    // Asynchronous reset in the middle of a run.
    set_abc();
    load_msg();
    cyc(8'h00, 4'b0010);
    for (int i = 0; i < 10; i++) begin @(posedge clk); #1; end
    check("mid_run_busy", 32'(uio_out[4]), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_status", 32'(uio_out), 32'h40);
    check("async_rst_uo_out", 32'(uo_out), 32'h00);
    check("async_rst_uio_oe", 32'(uio_oe), 32'hf0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
    check("post_rst_status", 32'(uio_out), 32'h40);
    check("post_rst_uo_out", 32'(uo_out), 32'h00);

    @(posedge clk); #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule

// File: doc/sha256_processor_dvirdc.md
Name: sha256_processor_dvirdc

Overview:
Single-block SHA-256 compression engine behind a Tiny-Tapeout-style 8-bit GPIO interface. Host streams one pre-padded 512-bit block in byte by byte, pulses start, waits for done, then reads the 32-byte digest byte by byte. It is the top-level user macro; padding is done by the host.

Parameters:
None; all widths fixed.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-high reset
ena  input  1  design-selected flag; ignored
ui_in  input  8  message data byte
uio_in  input  8  control: [0] wr, [1] start, [2] rd_next, [3] cont, [7:4] ignored
uio_out  output  8  status: [3:0]=0, [4] busy, [5] done, [6] ready (=~busy), [7]=0
uio_oe  output  8  constant 8'hF0
uo_out  output  8  current digest byte

Behaviour:
- Reset (async, rst=1): state IDLE; write pointer wptr=0; read pointer rptr=0; message buffer, round registers and digest H0..H7 cleared to 0; busy=0, done=0, uo_out=0.
- Controls are level-sampled every rising edge; one action per cycle per asserted bit.
- States: IDLE -> RUN (64 cycles) -> FINAL (1 cycle) -> DONE. DONE behaves as IDLE for wr/start.
- wr=1 in IDLE/DONE: ui_in stored at byte wptr, wptr=wptr+1 mod 64. Byte 0 = bits [31:24] of W0, byte 63 = bits [7:0] of W15 (big-endian). wr ignored while busy.
- start=1 in IDLE/DONE: load a..h from IV (6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19), or from current H if cont=1 and SHA256_MULTIBLOCK_EN defined; latch chaining base; clear done; wptr=0, rptr=0; enter RUN. start has priority over wr in the same cycle (wr dropped). start ignored while busy.
- RUN: one FIPS 180-4 round per cycle, t=0..63; W_t from 16-word sliding window (W_t = sigma1(W_t-2)+W_t-7+sigma0(W_t-15)+W_t-16 for t>=16), all adds mod 2^32; K table 64x32 constant.
- FINAL: H_i = base_i + working_i mod 2^32; next cycle done=1.
- Timing: busy=1 exactly 65 cycles starting the cycle after start is sampled; done rises together with busy falling (66th edge after start edge).
- Read: uo_out = digest byte rptr when done=1, else 0. Byte 0 = H0[31:24], byte 31 = H7[7:0]. rd_next=1 with done=1: rptr=rptr+1 mod 32 (wraps 31->0). rd_next ignored when done=0.
- Message buffer is consumed during RUN; host must reload all 64 bytes before next start. Bytes not rewritten are undefined.
- Reset mid-RUN aborts and clears everything as above.

Optional Feature:
SHA256_MULTIBLOCK_EN: when defined, start with cont=1 seeds a..h and chaining base from the existing H0..H7 (multi-block messages); digest remains readable until that start. When undefined, cont is ignored and every start uses the IV.

Test Plan:
- Reset: rst=1 mid-RUN -> busy=0, done=0, uo_out=0, uio_oe=8'hF0, ready=1 immediately (async).
- "abc" block (61 62 63 80, zeros, last byte 0x18), start -> busy 65 cycles, done; 32 rd_next reads give ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad; 33rd read wraps to 0xba.
- Empty message (80, 62 zeros... byte63=00) -> e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- wr and start in same cycle, and wr/start during busy -> ignored; digest unchanged vs clean run; rd_next before done -> rptr stays 0.
- Macro defined: "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" two blocks, second start cont=1 -> 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1; macro undefined -> cont ignored, second block hashed from IV.
